param_gray_code_counter: RTL and testbench
==========================================

// Module: param_gray_code_counter
// PURPOSE
//  Parametrised up/down Gray-code counter with built-in step prescaler; next generation of the
//  fixed 4-bit 1 Hz Gray counter. Adds width/rate generics, direction, enable, Gray-coded load,
//  sync clear, wrap/saturate mode and status pulses. Drives LED/display or CDC pointer logic.
// PARAMETERS
//  WIDTH     4           counter width in bits (>=2)
//  TICK_DIV  50_000_000  enabled clk cycles per count step (>=1; 50 MHz -> 1 step/s)
//  SATURATE  0           0: wrap modulo 2^WIDTH; 1: hold at end value (all-ones up / zero down)
// PORTS
//  clk          in   1      system clock, 50 MHz nominal
//  rst_n        in   1      synchronous reset, active low
//  i_en         in   1      1: prescaler runs; 0: prescaler and count frozen
//  i_up         in   1      direction, 1 = up, 0 = down; sampled only at step event
//  i_load       in   1      load request, 1-cycle
//  i_load_gray  in   WIDTH  load value, Gray-coded
//  i_clr        in   1      synchronous clear of count and prescaler
//  o_gray_cnt   out  WIDTH  registered Gray-coded count
//  o_bin_cnt    out  WIDTH  registered binary count (same cycle as o_gray_cnt)
//  o_tick       out  1      1-cycle pulse, cycle the new stepped value appears
//  o_wrap       out  1      1-cycle pulse on wrap (never asserts when SATURATE=1)
// BEHAVIOUR
//  - One clock, synchronous active-low reset. Reset: prescaler=0, o_bin_cnt=0, o_gray_cnt=0,
//    o_tick=0, o_wrap=0; applies on the first edge with rst_n=0, including mid-period.
//  - Prescaler pcnt, width $clog2(TICK_DIV) (min 1): counts 0..TICK_DIV-1 while i_en=1,
//    back to 0 after TICK_DIV-1. Holds value while i_en=0. step = i_en && pcnt==TICK_DIV-1.
//    TICK_DIV=1: step on every enabled cycle.
//  - Priority per edge: rst_n low > i_clr > i_load > step > hold.
//  - i_clr: pcnt<=0, bin<=0, gray<=0, o_tick/o_wrap<=0.
//  - i_load: bin <= gray2bin(i_load_gray) (b[W-1]=g[W-1], b[i]=b[i+1]^g[i]); gray <= i_load_gray;
//    pcnt<=0; no o_tick/o_wrap. Next step comes TICK_DIV enabled cycles later.
//  - step, up: bin<=bin+1 mod 2^W; wrap event if bin was all-ones.
//    step, down: bin<=bin-1 mod 2^W; wrap event if bin was 0.
//    SATURATE=1 at end value: bin holds, o_wrap stays 0, o_tick still pulses.
//  - gray next = bin_next ^ (bin_next >> 1), registered with bin; no combinational path to
//    output. Successive stepped values differ in exactly one bit (saturated hold: zero bits).
//  - o_tick/o_wrap: high for exactly the cycle after the step edge (aligned with new count);
//    otherwise 0. A step suppressed by i_clr/i_load produces no pulse.
//  - i_up changes between steps take effect at the next step; direction reversal steps back
//    one code (single-bit change).
//  - Latency: input at edge N -> outputs valid after edge N (1 cycle registered).
// TESTING
//  1 WIDTH=4,TICK_DIV=4,i_en=1,i_up=1 from reset -> o_gray 0000,0001,0011,0010,0110.. every 4
//    clks; 16th step -> 0000 with o_wrap=1 once; o_tick every 4 clks; Hamming dist 1 each step.
//  2 From 0, i_up=0 -> first step o_bin=1111, o_gray=1000, o_wrap=1; next o_gray=1001.
//  3 i_load=1,i_load_gray=1101 -> next cycle o_bin=1001,o_gray=1101, no o_tick; step exactly
//    4 enabled cycles later -> o_gray=1111.
//  4 i_en=0 for 10 clks at pcnt=2 -> count/pcnt frozen, no o_tick; step 2 enabled clks after
//    resume.
//  5 i_clr,i_load,step same edge -> o_bin=0,o_gray=0,no pulses; rst_n=0 mid-count at 0110 ->
//    all outputs 0 next edge.
//  6 SATURATE=1, up to o_gray=1000 -> holds 1000 on later steps, o_tick pulses, o_wrap=0.

Source files
------------

// File: rtl/param_gray_code_counter.sv
// Up/down Gray-code counter with a step prescaler, Gray-coded load, sync clear,
// wrap or saturate at the ends, and one-cycle tick/wrap status pulses.
module param_gray_code_counter #(
    parameter int WIDTH    = 4,
    parameter int TICK_DIV = 50_000_000,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_up,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_gray,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_gray_cnt,
    output logic [WIDTH-1:0] o_bin_cnt,
    output logic             o_tick,
    output logic             o_wrap
);

    localparam int              PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   P_LAST   = PW'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [PW-1:0]    r_pcnt;
    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_tick;
    logic             r_wrap;

    logic             w_step;
    logic             w_at_end;
    logic             w_hold;
    logic             w_wrap_evt;
    logic [WIDTH-1:0] w_bin_next;
    logic [WIDTH-1:0] w_gray_next;
    logic [WIDTH-1:0] w_load_bin;

    assign w_step     = i_en && (r_pcnt == P_LAST);
    assign w_at_end   = i_up ? (r_bin == ALL_ONES) : (r_bin == '0);
    assign w_hold     = SATURATE && w_at_end;
    assign w_wrap_evt = !SATURATE && w_at_end;

    always_comb begin
        w_bin_next = r_bin;
        if (!w_hold) begin
            w_bin_next = i_up ? (r_bin + WIDTH'(1)) : (r_bin - WIDTH'(1));
        end
    end

    assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

    // Binary bit i is the XOR of all Gray bits from the MSB down to i.
    always_comb begin
        w_load_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_load_bin[i] = ^(i_load_gray >> i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pcnt <= '0;
            r_bin  <= '0;
            r_gray <= '0;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else if (i_clr) begin
            r_pcnt <= '0;
            r_bin  <= '0;
            r_gray <= '0;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else if (i_load) begin
            r_pcnt <= '0;
            r_bin  <= w_load_bin;
            r_gray <= i_load_gray;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
            if (w_step) begin
                r_pcnt <= '0;
                r_bin  <= w_bin_next;
                r_gray <= w_gray_next;
                r_tick <= 1'b1;
                r_wrap <= w_wrap_evt;
            end else if (i_en) begin
                r_pcnt <= r_pcnt + PW'(1);
            end
        end
    end

    assign o_gray_cnt = r_gray;
    assign o_bin_cnt  = r_bin;
    assign o_tick     = r_tick;
    assign o_wrap     = r_wrap;

endmodule

// File: tb/tb_param_gray_code_counter.sv
// Bench for param_gray_code_counter: a wrapping and a saturating instance share
// stimulus; a numeric reference model feeds an expected queue drained by a monitor.
module tb_param_gray_code_counter;

    localparam int W  = 4;
    localparam int TD = 4;

    logic         clk;
    logic         rst_n;
    logic         i_en;
    logic         i_up;
    logic         i_load;
    logic [W-1:0] i_load_gray;
    logic         i_clr;
    logic [W-1:0] g0, b0, g1, b1;
    logic         t0, w0, t1, w1;

    param_gray_code_counter #(.WIDTH(W), .TICK_DIV(TD), .SATURATE(1'b0)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_up(i_up), .i_load(i_load),
        .i_load_gray(i_load_gray), .i_clr(i_clr),
        .o_gray_cnt(g0), .o_bin_cnt(b0), .o_tick(t0), .o_wrap(w0)
    );

    param_gray_code_counter #(.WIDTH(W), .TICK_DIV(TD), .SATURATE(1'b1)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_up(i_up), .i_load(i_load),
        .i_load_gray(i_load_gray), .i_clr(i_clr),
        .o_gray_cnt(g1), .o_bin_cnt(b1), .o_tick(t1), .o_wrap(w1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // expected entry: {sat instance, wrap instance}, each {gray, bin, tick, wrap}
    logic [2*(2*W+2)-1:0] exp_q[$];

    // reference model state, index 0 = wrapping, 1 = saturating
    int m_bin[2];
    int m_pc[2];
    bit m_tick[2];
    bit m_wrap[2];

    function automatic int to_gray(input int b);
        return (b ^ (b >> 1)) & ((1 << W) - 1);
    endfunction

    function automatic int from_gray(input int g);
        int b = 0;
        for (int i = W - 1; i >= 0; i--) begin
            b = b | ((((b >> (i + 1)) & 1) ^ ((g >> i) & 1)) << i);
        end
        return b;
    endfunction

    function automatic logic [2*W+1:0] pack(input int b, input bit t, input bit w);
        logic [W-1:0] gv;
        logic [W-1:0] bv;
        gv = W'(to_gray(b));
        bv = W'(b);
        return {gv, bv, t, w};
    endfunction

    task automatic check(input string name, input logic [2*W+1:0] act, input logic [2*W+1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got gray/bin/tick/wrap=%b want %b", name, $time, act, exp);
        end
    endtask

    // driver: apply one cycle of inputs and push the model's post-edge outputs
    task automatic drive(input logic rst, input logic en, input logic up, input logic ld,
                         input logic [W-1:0] lg, input logic clr);
        int maxv = (1 << W) - 1;
        @(negedge clk);
        rst_n = rst; i_en = en; i_up = up; i_load = ld; i_load_gray = lg; i_clr = clr;
        for (int s = 0; s < 2; s++) begin
            m_tick[s] = 1'b0;
            m_wrap[s] = 1'b0;
            if (!rst || clr) begin
                m_bin[s] = 0;
                m_pc[s]  = 0;
            end else if (ld) begin
                m_bin[s] = from_gray(int'(lg));
                m_pc[s]  = 0;
            end else if (en) begin
                if (m_pc[s] == TD - 1) begin
                    m_pc[s]   = 0;
                    m_tick[s] = 1'b1;
                    if (up && m_bin[s] == maxv) begin
                        if (s == 0) begin m_bin[s] = 0; m_wrap[s] = 1'b1; end
                    end else if (!up && m_bin[s] == 0) begin
                        if (s == 0) begin m_bin[s] = maxv; m_wrap[s] = 1'b1; end
                    end else begin
                        m_bin[s] = up ? m_bin[s] + 1 : m_bin[s] - 1;
                    end
                end else begin
                    m_pc[s] = m_pc[s] + 1;
                end
            end
        end
        exp_q.push_back({pack(m_bin[1], m_tick[1], m_wrap[1]), pack(m_bin[0], m_tick[0], m_wrap[0])});
    endtask

    task automatic run(input int n, input logic up);
        for (int k = 0; k < n; k++) drive(1'b1, 1'b1, up, 1'b0, '0, 1'b0);
    endtask

    // scoreboard monitor
    logic [2*(2*W+2)-1:0] mon_e;
    logic [W-1:0]         prev_g0;
    bit                   have_prev = 1'b0;

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("wrap_inst", {g0, b0, t0, w0}, mon_e[2*W+1:0]);
            check("sat_inst", {g1, b1, t1, w1}, mon_e[2*(2*W+2)-1:2*W+2]);
            if (t0 && have_prev) begin
                n_cmp++;
                if ($countones(g0 ^ prev_g0) != 1) begin
                    n_fail++;
                    $display("FAIL hamming @%0t: got %b -> %b want one bit changed", $time, prev_g0, g0);
                end
            end
            prev_g0   = g0;
            have_prev = 1'b1;
        end
    end

    // directed spot checks, sampled just after the edge that follows the last drive
    task automatic spot(input string name, input logic [2*W+1:0] exp);
        @(posedge clk);
        #2;
        check(name, {g0, b0, t0, w0}, exp);
    endtask

    initial begin
        rst_n = 1'b0; i_en = 1'b0; i_up = 1'b1; i_load = 1'b0; i_load_gray = '0; i_clr = 1'b0;
        for (int s = 0; s < 2; s++) begin m_bin[s] = 0; m_pc[s] = 0; end

        drive(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        spot("reset_state", 10'b0000_0000_0_0);

        // count up through a full cycle: 16 steps every 4 clocks
        run(3, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        spot("first_step_up", 10'b0001_0001_1_0);
        run(63, 1'b1);
        run(1, 1'b1);

        // down from zero wraps to all-ones
        drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        run(3, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        spot("down_wrap", 10'b1000_1111_1_1);
        run(4, 1'b0);

        // Gray load then a step exactly TD enabled cycles later
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'b1101, 1'b0);
        spot("load", 10'b1101_1001_0_0);
        run(3, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        spot("step_after_load", 10'b1111_1010_1_0);

        // freeze with prescaler at 2
        run(2, 1'b1);
        for (int k = 0; k < 10; k++) drive(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        run(1, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        spot("resume_step", 10'b1110_1011_1_0);

        // clear, load and step on the same edge: clear wins
        drive(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        run(3, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'b0111, 1'b1);
        spot("clr_priority", 10'b0000_0000_0_0);
        run(16, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        spot("reset_mid", 10'b0000_0000_0_0);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                  ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0,
                  W'($urandom_range(0, (1 << W) - 1)),
                  ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
        end

        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: got no completion want finish before 200000");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
